// File: rtl/psg_pkg.sv
// Shared definitions for the PSG write queue: FSM state encoding, SN76489
// register indices and the latch-flag bit position within a command byte.
package psg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    GAP    = 2'd2
  } psg_wq_state_e;

  // Register index carried in a latch byte (bits 6:4 in psg_d order).
  localparam int T1_FREQ    = 0;
  localparam int T1_ATTN    = 1;
  localparam int T2_FREQ    = 2;
  localparam int T2_ATTN    = 3;
  localparam int T3_FREQ    = 4;
  localparam int T3_ATTN    = 5;
  localparam int NOISE_CTRL = 6;
  localparam int NOISE_ATTN = 7;

  // psg_d[7] reaches PSG D0: 1 = latch/data byte, 0 = data-only byte.
  localparam int LATCH_BIT = 7;

  function automatic logic [2:0] psg_reg_index(input logic [7:0] cmd);
    return cmd[6:4];
  endfunction

  function automatic logic psg_is_latch(input logic [7:0] cmd);
    return cmd[LATCH_BIT];
  endfunction

endpackage

// File: rtl/psg_write_queue_if.sv
// CPU-side write port and PSG-side strobe bus of the PSG write queue.
// master: bus decode / PSG observer side; slave: the queue itself.
interface psg_write_queue_if;

  logic       cpu_wr;
  logic [7:0] cpu_d;
  logic       cpu_full;
  logic       cpu_empty;
  logic [7:0] psg_d;
  logic       psg_ce_n;
  logic       psg_we_n;

  modport master (
    output cpu_wr,
    output cpu_d,
    input  cpu_full,
    input  cpu_empty,
    input  psg_d,
    input  psg_ce_n,
    input  psg_we_n
  );

  modport slave (
    input  cpu_wr,
    input  cpu_d,
    output cpu_full,
    output cpu_empty,
    output psg_d,
    output psg_ce_n,
    output psg_we_n
  );

endinterface

// File: rtl/psg_byte_fifo.sv
// DEPTH x 8 synchronous byte FIFO with registered occupancy count.
// A push while full is ignored even when a pop happens in the same cycle,
// so the full flag alone decides whether a CPU byte is accepted.
module psg_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [7:0]               i_data,
  output logic [7:0]               o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/psg_write_queue.sv
// PSG write queue: buffers full-rate CPU byte writes and replays them to the
// sn76489 as ce_n/we_n strobes held until qualified by the PSG clk_en, with
// GAP_TICKS clk_en ticks of spacing between accepted writes.
// Optional build macro PSG_WQ_OVERFLOW_EN adds a sticky overflow flag
// (cpu_ovf) with a clear input (cpu_ovf_clr); without it drops are silent.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no write in flight; pops the FIFO head when count > 0
// STROBE | ce_n/we_n low, psg_d stable; released on an edge with clk_en = 1
// GAP    | counting clk_en ticks down from GAP_TICKS before the next strobe
module psg_write_queue
  import psg_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int GAP_TICKS = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clk_en,
  psg_write_queue_if.slave bus
`ifdef PSG_WQ_OVERFLOW_EN
  ,
  input  logic cpu_ovf_clr,
  output logic cpu_ovf
`endif
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [3:0]  GAP_LD = 4'(GAP_TICKS);

  psg_wq_state_e r_state;
  psg_wq_state_e w_state_nxt;
  logic [3:0]    r_gap_cnt;
  logic [3:0]    w_gap_nxt;
  logic          r_ce_n;
  logic          w_ce_n_nxt;
  logic [7:0]    r_psg_d;
  logic          w_pop;
  logic [7:0]    w_head;
  logic [AW:0]   w_count;
  logic          w_full;
  logic          w_empty;

  psg_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (bus.cpu_wr),
    .i_pop   (w_pop),
    .i_data  (bus.cpu_d),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // State, gap timer, strobe and data registers; reset releases the strobe
  // immediately so the PSG never sees a partial write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_gap_cnt <= 4'd0;
      r_ce_n    <= 1'b1;
      r_psg_d   <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_ce_n    <= w_ce_n_nxt;
      if (w_pop) begin
        r_psg_d <= w_head;
      end
    end
  end

  // Next-state logic: pop in IDLE, hold strobe until clk_en, then count the
  // gap down to its terminal count. Leaving GAP always costs one IDLE cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
    w_ce_n_nxt  = r_ce_n;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_ce_n_nxt  = 1'b0;
          w_state_nxt = STROBE;
        end
      end
      STROBE: begin
        if (clk_en) begin
          w_ce_n_nxt = 1'b1;
          if (GAP_TICKS == 0) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = GAP;
            w_gap_nxt   = GAP_LD;
          end
        end
      end
      GAP: begin
        if (clk_en) begin
          if (r_gap_cnt <= 4'd1) begin
            w_gap_nxt   = 4'd0;
            w_state_nxt = IDLE;
          end else begin
            w_gap_nxt = r_gap_cnt - 4'd1;
          end
        end
      end
      default: begin
        w_ce_n_nxt  = 1'b1;
        w_gap_nxt   = 4'd0;
        w_state_nxt = IDLE;
      end
    endcase
  end

`ifdef PSG_WQ_OVERFLOW_EN
  logic r_ovf;
  logic w_drop;

  assign w_drop  = bus.cpu_wr && w_full;
  assign cpu_ovf = r_ovf;

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (cpu_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end
`endif

  assign bus.cpu_full  = w_full;
  assign bus.cpu_empty = (w_count == '0) && (r_state == IDLE);
  assign bus.psg_d     = r_psg_d;
  assign bus.psg_ce_n  = r_ce_n;
  assign bus.psg_we_n  = r_ce_n;

endmodule

// File: tb/tb_psg_write_queue.sv
// Directed and constrained-random bench for psg_write_queue with a small
// SN76489 register model and an in-order delivery scoreboard.
module tb_psg_write_queue;
  import psg_pkg::*;

  localparam int DEPTH = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic clk_en  = 1'b0;
`ifdef PSG_WQ_OVERFLOW_EN
  logic cpu_ovf_clr = 1'b0;
  logic cpu_ovf;
`endif

  psg_write_queue_if bus_if ();

  psg_write_queue #(
    .DEPTH     (DEPTH),
    .GAP_TICKS (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clk_en      (clk_en),
    .bus         (bus_if)
`ifdef PSG_WQ_OVERFLOW_EN
    ,
    .cpu_ovf_clr (cpu_ovf_clr),
    .cpu_ovf     (cpu_ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int viol  = 0;
  int cyc   = 0;
  int mode  = 0;
  int n_push = 0;
  int n_wr   = 0;
  logic [7:0] exp_q [$];
  logic [9:0] preg [8];
  logic [2:0] latched = 3'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic calc_en(input int m, input int c);
    case (m)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (c % 16) == 0;
      default: return $urandom_range(0, 3) == 0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    clk_en = calc_en(mode, cyc);
  endtask

  task automatic set_mode(input int m);
    mode   = m;
    clk_en = calc_en(mode, cyc);
  endtask

  task automatic push_byte(input logic [7:0] d, input bit acc);
    bus_if.cpu_wr = 1'b1;
    bus_if.cpu_d  = d;
    if (acc) begin
      exp_q.push_back(d);
      n_push++;
    end
    tick();
    bus_if.cpu_wr = 1'b0;
  endtask

  task automatic drain(input string tag, input int bound);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || !bus_if.cpu_empty) && k < bound) begin
      tick();
      k++;
    end
    chk(tag, 32'(k < bound), 32'd1);
  endtask

  // PSG model: a write is the strobe low on an edge with clk_en high.
  task automatic psg_write(input logic [7:0] d);
    logic [2:0] idx;
    n_wr++;
    if (exp_q.size() == 0) begin
      chk("sb_unexpected", 32'(exp_q.size()), 32'd1);
    end else begin
      chk("sb_order", {24'd0, d}, {24'd0, exp_q.pop_front()});
    end
    if (d[7]) begin
      latched = d[6:4];
    end
    idx = latched;
    if (d[7]) begin
      preg[idx][3:0] = d[3:0];
    end else if (idx == 3'(T1_FREQ) || idx == 3'(T2_FREQ) || idx == 3'(T3_FREQ)) begin
      preg[idx][9:4] = d[5:0];
    end else begin
      preg[idx][3:0] = d[3:0];
    end
  endtask

  logic       pre_ce;
  logic       pre_we;
  logic       pre_en;
  logic       pre_rst;
  logic [7:0] pre_d;

  always @(posedge clk) begin
    pre_ce  = bus_if.psg_ce_n;
    pre_we  = bus_if.psg_we_n;
    pre_en  = clk_en;
    pre_rst = reset_n;
    pre_d   = bus_if.psg_d;
    if (pre_rst && !pre_ce && !pre_we && pre_en) begin
      psg_write(pre_d);
    end
    #1;
    if (reset_n) begin
      if (!pre_ce && !pre_en && bus_if.psg_ce_n) viol++;
      if (!pre_ce && !bus_if.psg_ce_n && bus_if.psg_d != pre_d) viol++;
      if (bus_if.psg_we_n != bus_if.psg_ce_n) viol++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_ce [5];
    int n_low;
    exp_ce = '{32'd1, 32'd1, 32'd1, 32'd0, 32'd1};
    for (int i = 0; i < 8; i++) preg[i] = 10'd0;
    bus_if.cpu_wr = 1'b0;
    bus_if.cpu_d  = 8'h00;

    // Reset state
    repeat (3) tick();
    chk("rst_ce_n",  32'(bus_if.psg_ce_n), 32'd1);
    chk("rst_we_n",  32'(bus_if.psg_we_n), 32'd1);
    chk("rst_psg_d", 32'(bus_if.psg_d), 32'h00);
    chk("rst_empty", 32'(bus_if.cpu_empty), 32'd1);
    chk("rst_full",  32'(bus_if.cpu_full), 32'd0);
    reset_n = 1'b1;
    set_mode(1);
    tick();

    // Continuous clk_en, back-to-back pushes of 0x9F then 0x0A
    push_byte(8'h9F, 1'b1);
    chk("t1_ce_after_push", 32'(bus_if.psg_ce_n), 32'd1);
    push_byte(8'h0A, 1'b1);
    chk("t1_ce_first", 32'(bus_if.psg_ce_n), 32'd0);
    chk("t1_d_first", 32'(bus_if.psg_d), 32'h9F);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t1_ce_seq%0d", i), 32'(bus_if.psg_ce_n), exp_ce[i]);
      if (i == 0) chk("t1_attn", 32'(preg[T1_ATTN]), 32'd15);
      if (i == 3) chk("t1_d_second", 32'(bus_if.psg_d), 32'h0A);
    end
    drain("t1_drain", 50);

    // Sparse clk_en: every 16th cycle
    set_mode(2);
    push_byte(8'h85, 1'b1);
    push_byte(8'h3F, 1'b1);
    begin
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 300) begin
        tick();
        k++;
      end
      chk("t2_done", 32'(k < 300), 32'd1);
    end
    set_mode(0);
    chk("t2_t1_freq", 32'(preg[T1_FREQ]), 32'h3F5);

    // Overflow with the FSM parked in GAP (clk_en held low)
    for (int i = 0; i < 9; i++) begin
      push_byte(8'h80 + 8'(i), i < 8);
      if (i == 6) chk("t3_full_7", 32'(bus_if.cpu_full), 32'd0);
      if (i == 7) chk("t3_full_8", 32'(bus_if.cpu_full), 32'd1);
      if (i == 8) chk("t3_full_9", 32'(bus_if.cpu_full), 32'd1);
`ifdef PSG_WQ_OVERFLOW_EN
      if (i == 7) chk("t3_ovf_8", 32'(cpu_ovf), 32'd0);
      if (i == 8) chk("t3_ovf_9", 32'(cpu_ovf), 32'd1);
`endif
    end
    chk("t3_not_empty", 32'(bus_if.cpu_empty), 32'd0);
    set_mode(1);
    drain("t3_drain", 300);
    chk("t3_full_after", 32'(bus_if.cpu_full), 32'd0);
`ifdef PSG_WQ_OVERFLOW_EN
    chk("t3_ovf_sticky", 32'(cpu_ovf), 32'd1);
    cpu_ovf_clr = 1'b1;
    tick();
    cpu_ovf_clr = 1'b0;
    chk("t3_ovf_clr", 32'(cpu_ovf), 32'd0);
`endif

    // Reset while strobing
    set_mode(0);
    push_byte(8'h5A, 1'b1);
    tick();
    chk("t4_ce_low", 32'(bus_if.psg_ce_n), 32'd0);
    chk("t4_d", 32'(bus_if.psg_d), 32'h5A);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t4_ce_rel", 32'(bus_if.psg_ce_n), 32'd1);
    chk("t4_we_rel", 32'(bus_if.psg_we_n), 32'd1);
    chk("t4_d_clr", 32'(bus_if.psg_d), 32'h00);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    set_mode(1);
    n_low = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!bus_if.psg_ce_n) n_low++;
    end
    chk("t4_no_strobe", 32'(n_low), 32'd0);
    chk("t4_empty", 32'(bus_if.cpu_empty), 32'd1);
`ifdef PSG_WQ_OVERFLOW_EN
    chk("t4_ovf_rst", 32'(cpu_ovf), 32'd0);
`endif

    // Random traffic with random clk_en
    n_push = 0;
    n_wr   = 0;
    set_mode(3);
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0 && exp_q.size() < DEPTH) begin
        push_byte(8'($urandom_range(0, 255)), 1'b1);
      end else begin
        tick();
      end
    end
    drain("t5_drain", 1000);
    chk("t5_count", 32'(n_wr), 32'(n_push));
    chk("t5_nonzero", 32'(n_push > 100), 32'd1);
    chk("strobe_rules", 32'(viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/psg_write_queue.md
Name: psg_write_queue

Overview:
- Sits between the 68k bus decode and the sn76489 tone/noise block.
- Accepts single-cycle CPU byte writes at full clk rate and buffers them in a FIFO.
- Replays each byte to the PSG as a ce_n/we_n strobe held until it is qualified by the PSG's clk_en.
- Enforces a minimum spacing between PSG writes, so no CPU write is lost to clk_en decimation.

Parameters:
- DEPTH, 8: FIFO entries; must be a power of 2, minimum 2.
- GAP_TICKS, 2: clk_en ticks after an accepted PSG write before the next strobe may start; range 0..15.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  PSG clock enable; the same signal that drives the sn76489 clk_en.
- cpu_wr  in  1  one-cycle write strobe from bus decode.
- cpu_d  in  8  command byte; bit 7 = latch/data flag (PSG D0).
- cpu_full  out  1  FIFO full (registered count == DEPTH).
- cpu_empty  out  1  FIFO empty and no write in flight.
- psg_d  out  8  byte to PSG; psg_d[7:0] wires to PSG d[0:7], so bit 7 -> D0.
- psg_ce_n  out  1  PSG chip enable, active low.
- psg_we_n  out  1  PSG write enable, active low; always equal to psg_ce_n.

Behaviour:
- Reset (async, reset_n low): FIFO pointers and count 0; state IDLE; psg_ce_n = psg_we_n = 1; psg_d = 0; cpu_full = 0; cpu_empty = 1; gap counter 0.
- Push:
  - cpu_wr high and count < DEPTH: cpu_d is written at the tail at that edge.
  - cpu_wr high with count == DEPTH: the byte is dropped, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle with count < DEPTH: count is unchanged.
- FSM states: IDLE, STROBE, GAP.
  - IDLE, count > 0: at the next edge, pop the head into psg_d, drive psg_ce_n/psg_we_n low, go to STROBE.
  - STROBE: outputs are held stable. On an edge where clk_en = 1, the PSG samples the write. At that same edge the strobes go high, and the state moves to GAP (GAP_TICKS > 0) or IDLE (GAP_TICKS = 0).
  - GAP: counts clk_en ticks. After GAP_TICKS ticks, return to IDLE. psg_d keeps its last value.
- Latency: a byte pushed into an empty queue at edge N (queue idle) drives the strobe low from edge N+1. The strobe rises at the first edge ≥ N+2 with clk_en = 1.
- clk_en high continuously: each strobe lasts exactly 1 cycle. The gap then lasts GAP_TICKS cycles, so throughput is one byte per GAP_TICKS+2 cycles.
- Back-to-back: a byte waiting in the FIFO during GAP is popped at the edge where the FSM leaves GAP→IDLE? No: it is popped at the first IDLE edge, which adds a 1-cycle IDLE bubble (fixed, simplifies verification).
- Pointer wrap: modulo DEPTH, natural wrap of log2(DEPTH)-bit pointers. count is log2(DEPTH)+1 bits.
- cpu_empty = (count == 0) && state == IDLE.
- Reset asserted mid-STROBE: strobes release immediately (async). The pending byte is lost and the PSG never sees a partial write.
- The queue never reorders or duplicates bytes. Each popped byte yields exactly one clk_en-qualified strobe.

Optional Feature:
- Macro PSG_WQ_OVERFLOW_EN.
- Defined, adds two ports:
  - cpu_ovf_clr  in  1: clears cpu_ovf.
  - cpu_ovf  out  1: sticky; set at the edge where a push is dropped; cleared at an edge with cpu_ovf_clr = 1. If a drop and a clear occur in the same cycle, the set wins. Reset value 0.
- Undefined: the ports are absent and drops are silent.

Decomposition:
- Shared package psg_pkg:
  - FSM state enum {IDLE, STROBE, GAP}.
  - PSG register index constants T1_FREQ..NOISE_ATTN (0..7).
  - Constant LATCH_BIT = 7.
- One sub-module, psg_byte_fifo: synchronous DEPTH x 8 FIFO with push/pop/count/full/empty, async active-low reset.

Test Plan:
- Reset while idle → strobes high, psg_d = 0x00, cpu_empty = 1, cpu_full = 0.
- clk_en = 1 constantly, GAP_TICKS = 2, push 0x9F then 0x0A on consecutive cycles:
  - 0x9F strobed low for 1 cycle, starting 1 cycle after its push.
  - 0x0A strobe starts exactly 4 cycles later (2-cycle gap + 1 IDLE bubble + 1).
  - PSG model reports T1_ATTN = 15.
- clk_en every 16th cycle, push 0x85 then 0x3F:
  - each strobe holds until the clk_en edge;
  - the PSG model's T1_FREQ = 0x3F5.
- Push 9 bytes 0x80..0x88 in 9 consecutive cycles (DEPTH = 8, clk_en = 0):
  - cpu_full = 1 after the 8th push; 0x88 is dropped;
  - cpu_ovf = 1 when the macro is defined;
  - after enabling clk_en, exactly 0x80..0x87 appear in order.
- Assert reset_n low while psg_ce_n = 0 → psg_ce_n/psg_we_n high in the same cycle. After release, cpu_empty = 1 and no further strobe occurs.
- Random pushes over 10k cycles with random clk_en → scoreboard confirms in-order, exactly-once delivery and no strobe that ends without a clk_en edge.
